// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display fetch > clear engine > game writer on one
// single-port RAM, plus the 2-stage pixel/sync pipeline toward the DAC.
module vga_fb_arbiter #(
  parameter int unsigned FB_W       = 160,
  parameter int unsigned FB_H       = 120,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned COLOR_W    = 12,
  parameter int unsigned AW         = 15
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               visible_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  input  logic [9:0]         position_x_i,
  input  logic [9:0]         position_y_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [COLOR_W-1:0] wr_data_i,
  input  logic               clear_i,
  input  logic [COLOR_W-1:0] clear_color_i,
  output logic               clear_busy_o,
  output logic               clear_done_o,
  output logic [AW-1:0]      mem_addr_o,
  output logic               mem_we_o,
  output logic [COLOR_W-1:0] mem_wdata_o,
  input  logic [COLOR_W-1:0] mem_rdata_i,
  output logic [COLOR_W-1:0] rgb_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               frame_start_o
);

  localparam int unsigned   NPIX   = FB_W * FB_H;
  localparam logic [AW-1:0] LAST_A = AW'(NPIX - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [AW-1:0]      disp_addr;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [COLOR_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [COLOR_W-1:0] pix_q;
  logic               done_q, done_d;
  logic               mem_we_d, wr_ready_d, slot;
  logic               slot_p1_q, vis_p1_q, hs_p1_q, vs_p1_q;
  logic               vis_p2_q, hs_p2_q, vs_p2_q;
  logic               frame_q;

  // One RAM read per scaled pixel, taken on the first screen column it covers.
  assign slot      = visible_i && (position_x_i[SCALE_LOG2-1:0] == '0);
  assign disp_addr = AW'(position_y_i >> SCALE_LOG2) * AW'(FB_W)
                   + AW'(position_x_i >> SCALE_LOG2);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    color_d     = color_q;
    done_d      = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    wr_ready_d  = 1'b0;

    if (slot) begin
      mem_addr_d = disp_addr;
    end else if (state_q == CLEAR) begin
      mem_addr_d  = cnt_q;
      mem_wdata_d = color_q;
      mem_we_d    = 1'b1;
      cnt_d       = cnt_q + AW'(1);
      if (cnt_q == LAST_A) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else begin
      wr_ready_d = 1'b1;
      if (wr_valid_i) begin
        mem_addr_d  = wr_addr_i;
        mem_wdata_d = wr_data_i;
        // Out-of-range writes complete the handshake but never reach the RAM.
        mem_we_d    = (32'(wr_addr_i) < NPIX);
      end
    end

    if (state_q == IDLE && clear_i) begin
      state_d = CLEAR;
      cnt_d   = '0;
      color_d = clear_color_color_sel(clear_color_i);
    end
  end

  function automatic logic [COLOR_W-1:0] clear_color_color_sel(input logic [COLOR_W-1:0] c);
    return c;
  endfunction

  // Combinational port outputs are forced to their idle values while in reset.
  assign wr_ready_o   = rst_ni & wr_ready_d;
  assign mem_we_o     = rst_ni & mem_we_d;
  assign mem_addr_o   = rst_ni ? mem_addr_d : '0;
  assign mem_wdata_o  = rst_ni ? mem_wdata_d : '0;
  assign clear_busy_o = (state_q == CLEAR);
  assign clear_done_o = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      color_q     <= '0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      color_q     <= color_d;
      done_q      <= done_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      frame_q     <= (position_x_i == '0) && (position_y_i == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_p1_q <= 1'b0;
      vis_p1_q  <= 1'b0;
      hs_p1_q   <= 1'b1;
      vs_p1_q   <= 1'b1;
      vis_p2_q  <= 1'b0;
      hs_p2_q   <= 1'b1;
      vs_p2_q   <= 1'b1;
      pix_q     <= '0;
    end else begin
      // Stage 1: timing flags alongside the RAM read in flight.
      slot_p1_q <= slot;
      vis_p1_q  <= visible_i;
      hs_p1_q   <= hsync_i;
      vs_p1_q   <= vsync_i;
      // Stage 2: capture read data; pix_q repeats across the scaled pixel.
      vis_p2_q  <= vis_p1_q;
      hs_p2_q   <= hs_p1_q;
      vs_p2_q   <= vs_p1_q;
      if (slot_p1_q) pix_q <= mem_rdata_i;
    end
  end

  assign rgb_o         = vis_p2_q ? pix_q : '0;
  assign hsync_o       = hs_p2_q;
  assign vsync_o       = vs_p2_q;
  assign frame_start_o = frame_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter on a shrunken 40x20 raster with a RAM model
// and a per-cycle reference model of arbitration, clearing and display.
module tb_vga_fb_arbiter;
  localparam int NPIX = 19200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vis, hs, vs;
  logic [9:0]  x, y;
  logic        wr_valid, wr_ready;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        clr, busy, done;
  logic [11:0] clr_col;
  logic [14:0] maddr;
  logic        mwe;
  logic [11:0] mwd, mrd, rgb;
  logic        hso, vso, fso;

  int n_cmp = 0, n_fail = 0;
  int n_done = 0, n_fs = 0, n_w123 = 0;
  int px, py;
  logic [11:0] ram [0:NPIX-1];

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .visible_i(vis), .hsync_i(hs), .vsync_i(vs),
    .position_x_i(x), .position_y_i(y),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .clear_i(clr), .clear_color_i(clr_col), .clear_busy_o(busy), .clear_done_o(done),
    .mem_addr_o(maddr), .mem_we_o(mwe), .mem_wdata_o(mwd), .mem_rdata_i(mrd),
    .rgb_o(rgb), .hsync_o(hso), .vsync_o(vso), .frame_start_o(fso)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous single-port RAM, read-before-write.
  initial begin
    for (int i = 0; i < NPIX; i++) ram[i] = 12'h0;
    mrd = 12'h0;
    forever begin
      @(posedge clk);
      mrd <= (int'(maddr) < NPIX) ? ram[int'(maddr)] : 12'h0;
      if (mwe && int'(maddr) < NPIX) ram[int'(maddr)] <= mwd;
    end
  end

  // Reference model and per-cycle compare.
  initial begin
    int  fbm [NPIX];
    bit  clearing, done_p, fs_p, hs1, hs2, vs1, vs2, slot, ewe, eready, dn;
    int  ccnt, ccol, last_a, last_pix, rgb1, rgb2, eaddr, ewd, xi, yi, cur;
    for (int i = 0; i < NPIX; i++) fbm[i] = 0;
    clearing = 0; done_p = 0; fs_p = 0; ccnt = 0; ccol = 0; last_a = 0; last_pix = 0;
    rgb1 = 0; rgb2 = 0; hs1 = 1; hs2 = 1; vs1 = 1; vs2 = 1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        clearing = 0; done_p = 0; fs_p = 0; last_a = 0; last_pix = 0;
        rgb1 = 0; rgb2 = 0; hs1 = 1; hs2 = 1; vs1 = 1; vs2 = 1;
        chk("rst_ready", int'(wr_ready), 0);
        chk("rst_we", int'(mwe), 0);
        chk("rst_addr", int'(maddr), 0);
        chk("rst_wdata", int'(mwd), 0);
        chk("rst_rgb", int'(rgb), 0);
        chk("rst_hsync", int'(hso), 1);
        chk("rst_vsync", int'(vso), 1);
        chk("rst_frame", int'(fso), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
      end else begin
        xi = int'(x); yi = int'(y);
        slot = vis && (xi % 4 == 0);
        ewe = 0; ewd = 0; eready = 0;
        if (slot) eaddr = (yi / 4) * 160 + xi / 4;
        else if (clearing) begin eaddr = ccnt; ewe = 1; ewd = ccol; end
        else begin
          eready = 1;
          if (wr_valid) begin
            eaddr = int'(wr_addr); ewd = int'(wr_data); ewe = (eaddr < NPIX);
          end else eaddr = last_a;
        end
        chk("wr_ready", int'(wr_ready), int'(eready));
        chk("mem_addr", int'(maddr), eaddr);
        chk("mem_we", int'(mwe), int'(ewe));
        if (ewe) chk("mem_wdata", int'(mwd), ewd);
        chk("clear_busy", int'(busy), int'(clearing));
        chk("clear_done", int'(done), int'(done_p));
        chk("frame_start", int'(fso), int'(fs_p));
        chk("rgb", int'(rgb), rgb2);
        chk("hsync", int'(hso), int'(hs2));
        chk("vsync", int'(vso), int'(vs2));
        if (done) n_done++;
        if (fso) n_fs++;
        if (mwe && mwd == 12'h123) n_w123++;
        // advance model state across the coming clock edge
        if (slot) begin cur = fbm[eaddr]; last_pix = cur; end
        else cur = last_pix;
        rgb2 = rgb1; rgb1 = vis ? cur : 0;
        hs2 = hs1; hs1 = hs; vs2 = vs1; vs1 = vs;
        if (ewe) fbm[eaddr] = ewd;
        last_a = eaddr;
        dn = 0;
        if (clearing) begin
          if (!slot) begin
            ccnt++;
            if (ccnt == NPIX) begin clearing = 0; dn = 1; end
          end
        end else if (clr) begin
          clearing = 1; ccnt = 0; ccol = int'(clr_col);
        end
        done_p = dn;
        fs_p = (xi == 0 && yi == 0);
      end
    end
  end

  // 40x20 raster: visible 32x16, hsync low x=34..36, vsync low y=17..18.
  task automatic drive();
    x = 10'(px); y = 10'(py);
    vis = (px < 32 && py < 16);
    hs = !(px >= 34 && px < 37);
    vs = !(py >= 17 && py < 19);
  endtask

  task automatic adv();
    @(posedge clk); #1;
    px++;
    if (px == 40) begin px = 0; py = (py + 1) % 20; end
  endtask

  task automatic cyc();
    drive(); adv();
  endtask

  task automatic goto(input int tx, input int ty);
    int n = 0;
    while (!(px == tx && py == ty) && n < 2000) begin cyc(); n++; end
  endtask

  initial begin
    int b;
    rst_n = 1; wr_valid = 1; wr_addr = 15'd50; wr_data = 12'h0; clr = 0; clr_col = 12'h0;
    px = 20; py = 8;
    drive();
    #2 rst_n = 0;
    #1;
    chk("async_rst_ready", int'(wr_ready), 0);
    chk("async_rst_we", int'(mwe), 0);
    chk("async_rst_addr", int'(maddr), 0);
    chk("async_rst_hsync", int'(hso), 1);
    chk("async_rst_rgb", int'(rgb), 0);
    wr_valid = 0;
    adv();
    repeat (3) cyc();
    rst_n = 1;

    // preload and an out-of-range write during vertical blanking
    goto(0, 18);
    wr_valid = 1; wr_addr = 15'd0; wr_data = 12'hF00;
    drive(); #2;
    chk("preload_ready", int'(wr_ready), 1);
    chk("preload_we", int'(mwe), 1);
    adv();
    wr_addr = 15'd1; wr_data = 12'h0F0;
    cyc();
    wr_addr = 15'd19200; wr_data = 12'hABC;
    drive(); #2;
    chk("oor_ready", int'(wr_ready), 1);
    chk("oor_we", int'(mwe), 0);
    chk("oor_addr", int'(maddr), 19200);
    adv();
    wr_valid = 0;

    // display from the top-left corner
    goto(0, 0);
    for (int k = 0; k < 10; k++) begin
      drive(); #2;
      if (k == 1) chk("frame_pulse_at_x1", int'(fso), 1);
      if (k == 2) chk("frame_pulse_at_x2", int'(fso), 0);
      if (k >= 2) chk("rgb_scaled", int'(rgb), (k - 2 < 4) ? 32'hF00 : 32'h0F0);
      adv();
    end

    goto(33, 0);
    for (int k = 0; k < 5; k++) begin
      drive(); #2;
      chk("hsync_delay", int'(hso), (k < 3) ? 1 : 0);
      adv();
    end

    // writer competing with display slots on line 8
    goto(0, 8);
    wr_valid = 1; wr_addr = 15'd100; wr_data = 12'h5A5;
    for (int k = 0; k < 16; k++) begin
      drive(); #2;
      chk("slot_ready", int'(wr_ready), int'(k % 4 != 0));
      if (k == 12) chk("slot_addr_x12", int'(maddr), 323);
      adv();
    end
    wr_valid = 0;

    // full clear starting at vblank, writer stalled, second clear ignored
    goto(0, 16);
    n_w123 = 0; n_done = 0;
    clr = 1; clr_col = 12'h123;
    cyc();
    clr = 0;
    drive(); #2;
    chk("clear_busy_start", int'(busy), 1);
    adv();
    wr_valid = 1; wr_addr = 15'd200; wr_data = 12'h777;
    repeat (500) cyc();
    clr = 1; clr_col = 12'h456;
    cyc();
    clr = 0;
    b = 0;
    while (n_done == 0 && b < 40000) begin cyc(); b++; end
    chk("clear_finished", int'(n_done != 0), 1);
    wr_valid = 0;
    repeat (10) cyc();
    chk("clear_write_count", n_w123, 19200);
    chk("clear_done_pulses", n_done, 1);
    chk("ram_first", int'(ram[0]), 32'h123);
    chk("ram_last", int'(ram[NPIX-1]), 32'h123);
    chk("ram_writer_after", int'(ram[200]), 32'h777);

    // two frames
    goto(0, 1);
    n_fs = 0;
    repeat (1600) cyc();
    chk("frame_pulse_count", n_fs, 2);

    // reset in the middle of a fill
    clr = 1; clr_col = 12'h321;
    cyc();
    clr = 0;
    repeat (100) cyc();
    drive(); #2 rst_n = 0;
    #1;
    chk("midclear_rst_busy", int'(busy), 0);
    chk("midclear_rst_done", int'(done), 0);
    adv();
    repeat (2) cyc();
    rst_n = 1;
    n_done = 0;
    repeat (200) cyc();
    chk("midclear_no_done", n_done, 0);
    chk("midclear_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM (1-cycle synchronous read) between the VGA display fetch and a game-logic writer, with an internal clear engine as a third requester.
- Sits between the VGA timing generator (x/y/visible/sync inputs) and the pins.
- Emits pipeline-aligned RGB and sync outputs.
- The framebuffer is down-scaled: each stored pixel covers a 2^SCALE_LOG2 square of screen pixels.

Parameters:
- FB_W, 160: framebuffer width in stored pixels.
- FB_H, 120: framebuffer height in stored pixels.
- SCALE_LOG2, 2: log2 of the screen-to-framebuffer scale factor.
- COLOR_W, 12: pixel colour width.
- AW, 15: address width; must be at least clog2(FB_W*FB_H).

Ports:
- clk_i  in  1  pixel clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- visible_i  in  1  timer active-region flag.
- hsync_i  in  1  timer hsync (active-low).
- vsync_i  in  1  timer vsync (active-low).
- position_x_i  in  10  timer horizontal counter.
- position_y_i  in  10  timer vertical counter.
- wr_valid_i  in  1  writer request.
- wr_ready_o  out  1  writer grant; the write occurs in the cycle where valid and ready are both high.
- wr_addr_i  in  AW  writer framebuffer address.
- wr_data_i  in  COLOR_W  writer pixel value.
- clear_i  in  1  single-cycle pulse that starts a full framebuffer fill.
- clear_color_i  in  COLOR_W  fill value; sampled on the accepted clear_i.
- clear_busy_o  out  1  high while a fill is in progress.
- clear_done_o  out  1  single-cycle pulse after the last fill write.
- mem_addr_o  out  AW  RAM address.
- mem_we_o  out  1  RAM write enable.
- mem_wdata_o  out  COLOR_W  RAM write data.
- mem_rdata_i  in  COLOR_W  RAM read data, valid one cycle after the address.
- rgb_o  out  COLOR_W  pixel to the DAC.
- hsync_o  out  1  hsync delayed 2 cycles.
- vsync_o  out  1  vsync delayed 2 cycles.
- frame_start_o  out  1  single-cycle pulse at the start of each frame.

Behaviour:
- Reset values: wr_ready_o=0, clear_busy_o=0, clear_done_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rgb_o=0, hsync_o=1, vsync_o=1, frame_start_o=0. The FSM resets to IDLE. Reset mid-fill abandons the fill with no done pulse.
- Display slot: asserted in a cycle when visible_i=1 and position_x_i[SCALE_LOG2-1:0]==0. In that cycle the display owns the port and no other requester is granted.
  - mem_addr_o = (position_y_i>>SCALE_LOG2)*FB_W + (position_x_i>>SCALE_LOG2), with mem_we_o=0.
- Priority: display slot > clear engine > writer.
  - All non-slot cycles, including blanking, are available to the lower-priority requesters.
  - In non-slot cycles with no grant, mem_addr_o holds its previous value and mem_we_o=0.
- Writer grant: wr_ready_o is combinational and equals !slot && state==IDLE. It does not depend on wr_valid_i.
  - On a grant: mem_addr_o=wr_addr_i, mem_wdata_o=wr_data_i, mem_we_o=1.
  - If wr_addr_i >= FB_W*FB_H, the handshake still completes but mem_we_o=0 and the write is dropped.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on clear_i. On that edge, clear_color_i is latched and the fill counter is reset to 0.
  - clear_i received while in CLEAR is ignored.
  - In CLEAR, every non-slot cycle writes the latched colour to the counter address, and the counter then increments.
  - The write to address FB_W*FB_H-1 causes CLEAR -> IDLE and raises clear_done_o for one cycle in the cycle after that write.
  - clear_busy_o = (state==CLEAR).
  - wr_ready_o=0 throughout CLEAR.
- Display pipeline:
  - Stage 1 registers the slot flag, visible_i, hsync_i and vsync_i.
  - Stage 2 registers the delayed syncs and loads pix_q from mem_rdata_i when the stage-1 slot flag is set. Otherwise pix_q holds.
  - rgb_o = visible_d2 ? pix_q : 0.
  - Total latency is 2 cycles from a timer position to its RGB and sync outputs.
  - Each pix_q value is displayed for 2^SCALE_LOG2 consecutive pixels.
- frame_start_o is registered: 1 for exactly the one cycle after the cycle in which position_x_i==0 and position_y_i==0.
- Address arithmetic is done at AW bits; the multiply by FB_W must not truncate within the valid range.

Test Plan:
- Reset: hold rst_ni=0 mid-line -> all outputs at their reset values immediately, without waiting for a clock edge; after release, the first rgb_o appears 2 cycles after the first visible x=0.
- Slot arbitration: wr_valid_i=1 continuously during visible line y=8 -> wr_ready_o=0 exactly when x%4==0; writes land at the other 3 of every 4 cycles; mem_addr_o on a slot at x=12 equals 2*160+3=323.
- Display data: preload address 0=0xF00 and address 1=0x0F0, then run from x=0,y=0 -> rgb_o=0xF00 for 4 pixels, then 0x0F0; hsync_o falls 2 cycles after hsync_i.
- Out-of-range write: wr_addr_i=19200 with wr_data_i=0xABC during blanking -> handshake completes, mem_we_o=0.
- Clear: clear_i with colour 0x123 at the start of vblank -> clear_busy_o high; 19200 writes of 0x123 skipping slot cycles; clear_done_o pulses once; second clear_i mid-fill is ignored; writer is stalled throughout.
- Frame pulse: across 2 frames -> exactly 2 frame_start_o pulses, each 1 cycle after (0,0); reset asserted mid-clear -> clear_busy_o=0 and no clear_done_o pulse.
